// File: rtl/bitcoin_nonce_sched.sv
// Bitcoin double-SHA256 nonce scheduler: drives one shared sha256 core
// through midstate, block 2 and second hash for each nonce of a job.
// Ports:
//   clk, reset           clock, async active-high reset
//   start, header        job request (sampled in IDLE), 640-bit header
//   busy, done           job in progress, one-cycle end-of-job pulse
//   res_valid/ready      result handshake carrying res_nonce/res_hash
//   core_*               sha256 core: start pulse, h_block, message,
//                        done pulse and digest (h0 at [31:0])
module bitcoin_nonce_sched #(
  parameter int unsigned NUM_NONCES = 16,
  parameter logic [31:0] NONCE_BASE = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [639:0] header,
  output logic         busy,
  output logic         done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic [31:0]  res_hash,
  output logic         core_start,
  output logic [255:0] core_h_block,
  output logic [511:0] core_message,
  input  logic         core_done,
  input  logic [255:0] core_h_out
);

  localparam int unsigned IW =
    (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_NONCES - 1);

  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_MID_ISSUE,
    S_MID_WAIT,
    S_P2_ISSUE,
    S_P2_WAIT,
    S_P3_ISSUE,
    S_P3_WAIT,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  // Header word 19 is the nonce slot and is never needed, so only
  // words 0..18 (header[639:32]) are kept.
  logic [607:0]    hdr_q, hdr_d;
  logic [255:0]    mid_q, mid_d;
  logic [255:0]    dig_q, dig_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rvld_q, rvld_d;
  logic [31:0]     rnonce_q, rnonce_d;
  logic [31:0]     rhash_q, rhash_d;
  logic [31:0]     nonce;
  logic            unused_hdr;

  assign unused_hdr = ^header[31:0];
  assign nonce      = NONCE_BASE + 32'(idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q    <= '0;
      mid_q    <= '0;
      dig_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvld_q   <= 1'b0;
      rnonce_q <= '0;
      rhash_q  <= '0;
    end else begin
      hdr_q    <= hdr_d;
      mid_q    <= mid_d;
      dig_q    <= dig_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rvld_q   <= rvld_d;
      rnonce_q <= rnonce_d;
      rhash_q  <= rhash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    mid_d    = mid_q;
    dig_d    = dig_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rvld_d   = rvld_q;
    rnonce_d = rnonce_q;
    rhash_d  = rhash_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hdr_d   = header[639:32];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MID_ISSUE;
        end
      end
      S_MID_ISSUE: state_d = S_MID_WAIT;
      S_MID_WAIT: begin
        if (core_done) begin
          mid_d   = core_h_out;
          state_d = S_P2_ISSUE;
        end
      end
      S_P2_ISSUE: state_d = S_P2_WAIT;
      S_P2_WAIT: begin
        if (core_done) begin
          dig_d   = core_h_out;
          state_d = S_P3_ISSUE;
        end
      end
      S_P3_ISSUE: state_d = S_P3_WAIT;
      S_P3_WAIT: begin
        if (core_done) begin
          rhash_d  = core_h_out[31:0];
          rnonce_d = nonce;
          rvld_d   = 1'b1;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rvld_q && res_ready) begin
          rvld_d = 1'b0;
          if (idx_q == LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_P2_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core operands are a pure function of state and registers that do
  // not change between issue and completion, so they stay stable for
  // the whole core run.
  always_comb begin
    core_start   = 1'b0;
    core_h_block = '0;
    core_message = '0;
    unique case (state_q)
      S_MID_ISSUE, S_MID_WAIT: begin
        core_start   = (state_q == S_MID_ISSUE);
        core_h_block = IV;
        core_message = hdr_q[607:96];
      end
      S_P2_ISSUE, S_P2_WAIT: begin
        core_start   = (state_q == S_P2_ISSUE);
        core_h_block = mid_q;
        core_message = {hdr_q[95:0], nonce, 32'h8000_0000,
                        {10{32'h0}}, 32'd640};
      end
      S_P3_ISSUE, S_P3_WAIT: begin
        core_start   = (state_q == S_P3_ISSUE);
        core_h_block = IV;
        // digest words go out h0 first, big-endian word order
        for (int i = 0; i < 8; i++) begin
          core_message[511-32*i -: 32] = dig_q[32*i +: 32];
        end
        core_message[255:0] = {32'h8000_0000, {6{32'h0}}, 32'd256};
      end
      default: begin
        core_start = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = rvld_q;
  assign res_nonce = rnonce_q;
  assign res_hash  = rhash_q;

endmodule

// File: tb/tb_bitcoin_nonce_sched.sv
// Self-checking bench for bitcoin_nonce_sched: behavioural sha256 core,
// byte-level double-SHA256 reference, result tables and corner sequences.
module tb_bitcoin_nonce_sched;

  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          stall;
    logic [31:0] nonce;
    logic [31:0] hash;
  } vec_t;

  typedef struct {
    logic [255:0] hb;
    logic [511:0] msg;
  } inv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [1:0]         start;
  logic [1:0]         rrdy;
  logic [639:0]       hdr_in;
  wire  [1:0]         busy, done, rvld, cs, cdone;
  wire  [1:0][31:0]   rnonce, rhash;
  wire  [1:0][255:0]  chb, chout;
  wire  [1:0][511:0]  cmsg;

  bitcoin_nonce_sched #(
    .NUM_NONCES(16), .NONCE_BASE(32'h0000_0000)
  ) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .header(hdr_in),
    .busy(busy[0]), .done(done[0]), .res_valid(rvld[0]),
    .res_ready(rrdy[0]), .res_nonce(rnonce[0]), .res_hash(rhash[0]),
    .core_start(cs[0]), .core_h_block(chb[0]),
    .core_message(cmsg[0]), .core_done(cdone[0]),
    .core_h_out(chout[0])
  );

  bitcoin_nonce_sched #(
    .NUM_NONCES(2), .NONCE_BASE(32'hFFFF_FFFF)
  ) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .header(hdr_in),
    .busy(busy[1]), .done(done[1]), .res_valid(rvld[1]),
    .res_ready(rrdy[1]), .res_nonce(rnonce[1]), .res_hash(rhash[1]),
    .core_start(cs[1]), .core_h_block(chb[1]),
    .core_message(cmsg[1]), .core_done(cdone[1]),
    .core_h_out(chout[1])
  );

  // ---------------- SHA-256 primitives ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(
    input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    a = hin[31:0];    b = hin[63:32];   c = hin[95:64];
    d = hin[127:96];  e = hin[159:128]; f = hin[191:160];
    g = hin[223:192]; hh = hin[255:224];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
         + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
         + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + hh, hin[223:192] + g,
            hin[191:160] + f,  hin[159:128] + e,
            hin[127:96] + d,   hin[95:64] + c,
            hin[63:32] + b,    hin[31:0] + a};
  endfunction

  // Full SHA-256 of a byte string with standard padding.
  function automatic logic [255:0] sha256_bytes(input logic [7:0] data[$]);
    logic [7:0]   q[$];
    logic [255:0] h;
    logic [511:0] m;
    logic [63:0]  bits;
    q = data;
    bits = 64'(q.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
    h = IV;
    for (int blk = 0; blk < q.size() / 64; blk++) begin
      for (int i = 0; i < 64; i++) m[511-8*i -: 8] = q[64*blk + i];
      h = sha_compress(h, m);
    end
    return h;
  endfunction

  // H0 of SHA256(SHA256(header words 0..18 ++ nonce)).
  function automatic logic [31:0] ref_h0(
    input logic [639:0] h, input logic [31:0] nonce);
    logic [7:0]   q[$];
    logic [7:0]   q2[$];
    logic [31:0]  wd;
    logic [255:0] d1, d2;
    for (int w = 0; w < 19; w++) begin
      wd = h[639-32*w -: 32];
      for (int b = 3; b >= 0; b--) q.push_back(wd[8*b +: 8]);
    end
    for (int b = 3; b >= 0; b--) q.push_back(nonce[8*b +: 8]);
    d1 = sha256_bytes(q);
    for (int w = 0; w < 8; w++) begin
      wd = d1[32*w +: 32];
      for (int b = 3; b >= 0; b--) q2.push_back(wd[8*b +: 8]);
    end
    d2 = sha256_bytes(q2);
    return d2[31:0];
  endfunction

  // ---------------- behavioural sha256 core ----------------
  logic [1:0]        m_busy, m_first, m_done, m_spur;
  logic [1:0][2:0]   m_cnt;
  logic [1:0][255:0] m_hb, m_out;
  logic [1:0][511:0] m_msg;
  bit                spur_en;
  int                start_cnt [2];
  int                stab_err;
  int                proto_err;
  inv_t              log_q[$];

  assign cdone = m_done | m_spur;
  assign chout = m_out;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= '0;
      m_first <= '0;
      m_done  <= '0;
      m_spur  <= '0;
      m_cnt   <= '0;
      m_hb    <= '0;
      m_msg   <= '0;
      m_out   <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        m_spur[k] <= spur_en & m_done[k];
        if (!m_busy[k]) begin
          if (cs[k]) begin
            m_busy[k]  <= 1'b1;
            m_first[k] <= 1'b1;
            m_hb[k]    <= chb[k];
            m_cnt[k]   <= 3'($urandom_range(1, 5));
          end
        end else begin
          m_first[k] <= 1'b0;
          if (m_first[k]) m_msg[k] <= cmsg[k];
          if (m_cnt[k] == 3'd0) begin
            m_done[k] <= 1'b1;
            m_out[k]  <= sha_compress(m_hb[k], m_msg[k]);
            m_busy[k] <= 1'b0;
          end else begin
            m_cnt[k] <= m_cnt[k] - 3'd1;
          end
        end
      end
    end
  end

  // Protocol watch: start counts, operand stability, illegal starts.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (cs[k]) start_cnt[k] <= start_cnt[k] + 1;
        if (m_busy[k]) begin
          if (cs[k]) proto_err <= proto_err + 1;
          if (chb[k] != m_hb[k]) stab_err <= stab_err + 1;
          if (!m_first[k] && cmsg[k] != m_msg[k])
            stab_err <= stab_err + 1;
        end
        if (m_done[k] && cs[k]) proto_err <= proto_err + 1;
      end
      if (m_busy[0] && m_first[0]) log_q.push_back('{m_hb[0], cmsg[0]});
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_ctl"}, {busy[k], done[k], rvld[k], cs[k]}, 0);
    check({tag, "_res"}, {rnonce[k], rhash[k]}, 0);
    check({tag, "_hblk"}, chb[k], 0);
    check({tag, "_msg"}, cmsg[k], 0);
  endtask

  task automatic run_job(input int k, input logic [639:0] h,
                         input vec_t tbl[$], input bit use_stall,
                         input bit abuse);
    int s0, sc, cnt;
    bit ok;
    logic [31:0] hn, hh;
    s0 = start_cnt[k];
    @(negedge clk);
    hdr_in = h;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    check($sformatf("busy_after_start%0d", k), busy[k], 1);
    if (abuse) hdr_in = ~h;
    for (int i = 0; i < tbl.size(); i++) begin
      cnt = 0;
      while (!rvld[k] && cnt < 5000) begin
        start[k] = (abuse && (cnt % 7 == 3)) ? 1'b1 : 1'b0;
        @(negedge clk);
        cnt++;
      end
      start[k] = 1'b0;
      check($sformatf("valid_timeout%0d_%0d", k, i), rvld[k], 1);
      check($sformatf("early_done%0d_%0d", k, i), done[k], 0);
      if (use_stall && tbl[i].stall > 0) begin
        hn = rnonce[k];
        hh = rhash[k];
        sc = start_cnt[k];
        ok = 1'b1;
        repeat (tbl[i].stall) begin
          @(negedge clk);
          if (!rvld[k] || rnonce[k] != hn || rhash[k] != hh) ok = 1'b0;
        end
        check($sformatf("stall_hold%0d", i), ok, 1);
        check($sformatf("stall_nostart%0d", i), start_cnt[k], sc);
      end
      check($sformatf("nonce%0d_%0d", k, i), rnonce[k], tbl[i].nonce);
      check($sformatf("hash%0d_%0d", k, i), rhash[k], tbl[i].hash);
      rrdy[k] = 1'b1;
      @(negedge clk);
      rrdy[k] = 1'b0;
      check($sformatf("valid_clear%0d_%0d", k, i), rvld[k], 0);
    end
    check($sformatf("done_pulse%0d", k), {done[k], busy[k]}, 2'b10);
    @(negedge clk);
    check($sformatf("done_drop%0d", k), done[k], 0);
    repeat (10) @(negedge clk);
    check($sformatf("start_count%0d", k), start_cnt[k] - s0,
          1 + 2 * tbl.size());
  endtask

  // ---------------- test sequence ----------------
  logic [639:0] hdr;
  logic [255:0] mid, d1;
  logic [7:0]   abc[$];
  vec_t         vecs0[$];
  vec_t         vecs1[$];
  int           s0, cnt;

  initial begin
    reset = 1'b1;
    start = '0;
    rrdy = '0;
    hdr_in = '0;
    spur_en = 1'b0;
    stab_err = 0;
    proto_err = 0;
    start_cnt[0] = 0;
    start_cnt[1] = 0;
    for (int w = 0; w < 20; w++) hdr[639-32*w -: 32] = $urandom;

    for (int i = 0; i < 16; i++)
      vecs0.push_back('{(i == 3) ? 50 : 0, 32'(i), ref_h0(hdr, 32'(i))});
    vecs1.push_back('{0, 32'hFFFF_FFFF, ref_h0(hdr, 32'hFFFF_FFFF)});
    vecs1.push_back('{0, 32'h0000_0000, ref_h0(hdr, 32'h0000_0000)});

    abc = '{8'h61, 8'h62, 8'h63};
    check("sha_abc", sha256_bytes(abc),
          {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
           32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf});

    repeat (3) @(negedge clk);
    check_idle(0, "por0");
    check_idle(1, "por1");
    reset = 1'b0;
    @(negedge clk);

    // reset in the middle of P2_WAIT
    s0 = start_cnt[0];
    hdr_in = hdr;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cnt = 0;
    while (start_cnt[0] - s0 < 2 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_p2", start_cnt[0] - s0, 2);
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = start_cnt[0];
    repeat (20) @(negedge clk);
    check("rst_nostart", start_cnt[0], s0);
    check_idle(0, "postrst");

    // clean run with backpressure on result 3
    log_q.delete();
    run_job(0, hdr, vecs0, 1'b1, 1'b0);

    check("inv_count", log_q.size(), 33);
    mid = sha_compress(IV, hdr[639:128]);
    if (log_q.size() == 33) begin
      check("mid_hblk", log_q[0].hb, IV);
      check("mid_msg", log_q[0].msg, hdr[639:128]);
      for (int j = 1; j < 33; j++) begin
        if (j % 2 == 1) begin
          check($sformatf("p2_hblk%0d", j), log_q[j].hb, mid);
          check($sformatf("p2_w0_2_%0d", j), log_q[j].msg[511:416],
                hdr[127:32]);
          check($sformatf("p2_nonce%0d", j), log_q[j].msg[415:384],
                (j - 1) / 2);
          check($sformatf("p2_w15_%0d", j), log_q[j].msg[31:0], 640);
        end else begin
          d1 = sha_compress(log_q[j-1].hb, log_q[j-1].msg);
          check($sformatf("p3_hblk%0d", j), log_q[j].hb, IV);
          check($sformatf("p3_w0_%0d", j), log_q[j].msg[511:480],
                d1[31:0]);
          check($sformatf("p3_w7_%0d", j), log_q[j].msg[287:256],
                d1[255:224]);
          check($sformatf("p3_w8_%0d", j), log_q[j].msg[255:224],
                32'h8000_0000);
          check($sformatf("p3_w15_%0d", j), log_q[j].msg[31:0], 256);
        end
      end
    end

    // abuse run: starts while busy, header changes, spurious dones
    spur_en = 1'b1;
    run_job(0, hdr, vecs0, 1'b0, 1'b1);
    spur_en = 1'b0;

    // nonce wrap on the second instance
    run_job(1, hdr, vecs1, 1'b0, 1'b0);

    check("operand_stability", stab_err, 0);
    check("core_protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule
